// File: rtl/tlb_lru_state_pkg.sv
// Shared constants and state encoding for the TLB LRU rank storage.
package tlb_lru_state_pkg;

    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_LRU_BITS = 2;
    localparam int TLB_SET_BITS = 4;
    localparam int WAY_BITS     = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } lru_state_t;

endpackage

// File: rtl/tlb_lru_state_rank_update.sv
// Combinational next-rank function: makes one way MRU and closes the gap it
// leaves, so a permutation of ranks stays a permutation.
module tlb_lru_rank_update
    import tlb_lru_state_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int LRU_BITS = DEF_LRU_BITS
) (
    input  logic [NUM_WAYS*LRU_BITS-1:0] ranks_in,
    input  logic [WAY_BITS-1:0]          way,
    output logic [NUM_WAYS*LRU_BITS-1:0] ranks_out
);

    logic                way_ok;
    logic [LRU_BITS-1:0] old_rank;

    // A way index beyond the configured ways can only occur with fewer than four ways
    if ((1 << WAY_BITS) > NUM_WAYS) begin : g_partial_ways
        assign way_ok = (32'(way) < NUM_WAYS);
    end else begin : g_full_ways
        assign way_ok = 1'b1;
    end

    assign old_rank = way_ok ? ranks_in[way*LRU_BITS +: LRU_BITS] : '0;

    // Touched way becomes MRU; every way ranked above its old rank moves down one
    always_comb begin
        ranks_out = ranks_in;
        if (way_ok) begin
            for (int j = 0; j < NUM_WAYS; j++) begin
                if (WAY_BITS'(j) == way) begin
                    ranks_out[j*LRU_BITS +: LRU_BITS] = LRU_BITS'(NUM_WAYS - 1);
                end else if (ranks_in[j*LRU_BITS +: LRU_BITS] > old_rank) begin
                    ranks_out[j*LRU_BITS +: LRU_BITS] = ranks_in[j*LRU_BITS +: LRU_BITS] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tlb_lru_state.sv
// Per-set LRU rank array with init/flush walk, update port and a one-cycle
// lookup port that forwards a same-cycle update to the same set.
module tlb_lru_state
    import tlb_lru_state_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int LRU_BITS = DEF_LRU_BITS,
    parameter int SET_BITS = TLB_SET_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_req,
    output logic                         busy,
    input  logic                         upd_valid,
    output logic                         upd_ready,
    input  logic [SET_BITS-1:0]          upd_set,
    input  logic [WAY_BITS-1:0]          upd_way,
    input  logic                         rd_valid,
    input  logic [SET_BITS-1:0]          rd_set,
    output logic                         rd_resp_valid,
    output logic [NUM_WAYS*LRU_BITS-1:0] rd_lru_count
);

    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int RW       = NUM_WAYS * LRU_BITS;

    lru_state_t          state;
    logic [SET_BITS-1:0] walk_idx;
    logic [RW-1:0]       rank_mem [NUM_SETS];

    logic [RW-1:0]       init_ranks;
    logic [RW-1:0]       upd_old;
    logic [RW-1:0]       upd_new;
    logic [RW-1:0]       rd_next;
    logic [RW-1:0]       wr_data;
    logic [SET_BITS-1:0] wr_set;
    logic                wr_en;
    logic                idle;
    logic                upd_fire;
    logic                rd_fire;

    assign idle      = (state == ST_IDLE);
    assign busy      = (state == ST_WALK);
    assign upd_ready = idle && !flush_req;
    assign upd_fire  = upd_valid && upd_ready;
    assign rd_fire   = rd_valid && idle && !flush_req;

    // Identity permutation written by the walk: way i gets rank i
    always_comb begin
        init_ranks = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            init_ranks[i*LRU_BITS +: LRU_BITS] = LRU_BITS'(i);
        end
    end

    assign upd_old = rank_mem[upd_set];

    tlb_lru_rank_update #(
        .NUM_WAYS (NUM_WAYS),
        .LRU_BITS (LRU_BITS)
    ) u_rank_update (
        .ranks_in  (upd_old),
        .way       (upd_way),
        .ranks_out (upd_new)
    );

    // Single write port: the walk owns it while busy, accepted updates otherwise
    always_comb begin
        wr_en   = 1'b0;
        wr_set  = upd_set;
        wr_data = upd_new;
        if (busy) begin
            wr_en   = 1'b1;
            wr_set  = walk_idx;
            wr_data = init_ranks;
        end else if (upd_fire) begin
            wr_en = 1'b1;
        end
    end

    // Rank array has no reset; the walk after reset rewrites every set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            rank_mem[wr_set] <= wr_data;
        end
    end

    // Walk FSM: one set per cycle, a flush during the walk restarts it from set 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WALK;
            walk_idx <= '0;
        end else begin
            case (state)
                ST_WALK: begin
                    if (flush_req) begin
                        walk_idx <= '0;
                    end else if (walk_idx == SET_BITS'(NUM_SETS - 1)) begin
                        state    <= ST_IDLE;
                        walk_idx <= '0;
                    end else begin
                        walk_idx <= walk_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush_req) begin
                        state    <= ST_WALK;
                        walk_idx <= '0;
                    end
                end
                default: begin
                    state    <= ST_WALK;
                    walk_idx <= '0;
                end
            endcase
        end
    end

    // Lookup data forwards the post-update ranks when the same set is touched this cycle
    assign rd_next = (upd_fire && (upd_set == rd_set)) ? upd_new : rank_mem[rd_set];

    // Registered lookup response; data holds its last value when no lookup fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_resp_valid <= 1'b0;
            rd_lru_count  <= '0;
        end else begin
            rd_resp_valid <= rd_fire;
            if (rd_fire) begin
                rd_lru_count <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_tlb_lru_state.sv
// Scoreboard bench for tlb_lru_state: directed vectors with hand-computed
// ranks plus a recency-list reference model for the random phase.
module tb_tlb_lru_state;
    import tlb_lru_state_pkg::*;

    localparam int NW = 4;
    localparam int LB = 2;
    localparam int SB = 4;
    localparam int NS = 16;
    localparam int RW = NW * LB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush_req = 1'b0;
    logic          upd_valid = 1'b0;
    logic          rd_valid = 1'b0;
    logic [SB-1:0] upd_set = '0;
    logic [SB-1:0] rd_set = '0;
    logic [1:0]    upd_way = '0;
    logic          busy;
    logic          upd_ready;
    logic          rd_resp_valid;
    logic [RW-1:0] rd_lru_count;

    int            n_vec = 0;
    int            n_err = 0;
    logic [RW-1:0] sb_q[$];
    logic [RW-1:0] mon_exp;
    int            ord[NS][NW];
    int            cyc;
    int            rdy;

    tlb_lru_state dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_req     (flush_req),
        .busy          (busy),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_set       (upd_set),
        .upd_way       (upd_way),
        .rd_valid      (rd_valid),
        .rd_set        (rd_set),
        .rd_resp_valid (rd_resp_valid),
        .rd_lru_count  (rd_lru_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model keeps each set as a list ordered from LRU to MRU
    function automatic void model_reset();
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < NW; p++)
                ord[s][p] = p;
    endfunction

    function automatic void model_touch(int s, int w);
        int pos = 0;
        for (int p = 0; p < NW; p++)
            if (ord[s][p] == w) pos = p;
        for (int p = pos; p < NW - 1; p++)
            ord[s][p] = ord[s][p+1];
        ord[s][NW-1] = w;
    endfunction

    function automatic logic [RW-1:0] model_ranks(int s);
        logic [RW-1:0] r = '0;
        for (int p = 0; p < NW; p++)
            r[ord[s][p]*LB +: LB] = LB'(p);
        return r;
    endfunction

    function automatic logic [31:0] perm_mask(logic [RW-1:0] r);
        logic [31:0] m = '0;
        for (int w = 0; w < NW; w++)
            m[r[w*LB +: LB]] = 1'b1;
        return m;
    endfunction

    // Drives one cycle of requests while idle and queues the expected lookup response
    task automatic applyStimulus(input logic uv, input logic [SB-1:0] us, input logic [1:0] uw,
                                 input logic rv, input logic [SB-1:0] rs,
                                 input logic [RW-1:0] exp_rd, input bit use_model);
        @(posedge clk);
        #1;
        upd_valid = uv;
        upd_set   = us;
        upd_way   = uw;
        rd_valid  = rv;
        rd_set    = rs;
        if (uv) model_touch(int'(us), int'(uw));
        if (rv) sb_q.push_back(use_model ? model_ranks(int'(rs)) : exp_rd);
    endtask

    // Counts busy cycles from the next falling edge, bounded
    task automatic count_busy(output int cycles, output int ready_seen);
        cycles = 0;
        ready_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (upd_ready) ready_seen++;
        end
    endtask

    // Monitor: every response is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rd_resp_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_rd_resp: got ranks 0x%0h, expected no response", rd_lru_count);
            end else begin
                mon_exp = sb_q.pop_front();
                checkOutput("rd_lru_count", 32'(rd_lru_count), 32'(mon_exp));
                checkOutput("rank_permutation", perm_mask(rd_lru_count), 32'hF);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 1);
        checkOutput("reset_upd_ready", 32'(upd_ready), 0);
        checkOutput("reset_rd_resp_valid", 32'(rd_resp_valid), 0);
        checkOutput("reset_rd_lru_count", 32'(rd_lru_count), 0);

        // Initial walk
        @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(cyc, rdy);
        checkOutput("init_busy_cycles", cyc, 16);
        checkOutput("upd_ready_during_init", rdy, 0);
        checkOutput("upd_ready_idle", 32'(upd_ready), 1);

        // Directed vectors with hand-computed ranks {way3,way2,way1,way0}
        applyStimulus(0, 4'd0, 2'd0, 1, 4'd3, 8'hE4, 0);
        applyStimulus(1, 4'd3, 2'd0, 0, 4'd0, 8'h00, 0);
        applyStimulus(0, 4'd0, 2'd0, 1, 4'd3, 8'h93, 0);
        applyStimulus(1, 4'd9, 2'd2, 1, 4'd3, 8'h93, 0);
        applyStimulus(0, 4'd0, 2'd0, 1, 4'd9, 8'hB4, 0);
        applyStimulus(1, 4'd3, 2'd2, 1, 4'd3, 8'h72, 0);
        applyStimulus(1, 4'd5, 2'd3, 0, 4'd0, 8'h00, 0);
        applyStimulus(0, 4'd0, 2'd0, 1, 4'd5, 8'hE4, 0);
        applyStimulus(1, 4'd7, 2'd1, 1, 4'd7, 8'h9C, 0);
        applyStimulus(0, 4'd0, 2'd0, 0, 4'd0, 8'h00, 0);

        // Flush with requests held, restarted during the eighth walk cycle
        @(posedge clk);
        #1;
        flush_req = 1'b1;
        upd_valid = 1'b1;
        upd_set   = 4'd0;
        upd_way   = 2'd0;
        rd_valid  = 1'b1;
        rd_set    = 4'd3;
        @(negedge clk);
        checkOutput("upd_ready_on_flush", 32'(upd_ready), 0);
        cyc = 0;
        rdy = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1 flush_req = (cyc == 7);
            @(negedge clk);
            if (!busy) break;
            cyc++;
            if (upd_ready) rdy++;
        end
        upd_valid = 1'b0;
        rd_valid  = 1'b0;
        flush_req = 1'b0;
        model_reset();
        checkOutput("flush_busy_cycles", cyc, 24);
        checkOutput("upd_ready_during_flush", rdy, 0);
        for (int s = 0; s < NS; s++)
            applyStimulus(0, 4'd0, 2'd0, 1, SB'(s), 8'hE4, 0);

        // Reset dropped in the middle of an update stream
        applyStimulus(1, 4'd2, 2'd1, 1, 4'd2, 8'h00, 1);
        applyStimulus(1, 4'd2, 2'd0, 1, 4'd2, 8'h00, 1);
        #2 rst_n = 1'b0;
        sb_q.delete();
        model_reset();
        #1;
        checkOutput("midupd_rst_busy", 32'(busy), 1);
        checkOutput("midupd_rst_upd_ready", 32'(upd_ready), 0);
        checkOutput("midupd_rst_rd_resp_valid", 32'(rd_resp_valid), 0);
        checkOutput("midupd_rst_rd_lru_count", 32'(rd_lru_count), 0);
        upd_valid = 1'b0;
        rd_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset dropped again partway through the walk
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("midwalk_rst_busy", 32'(busy), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        count_busy(cyc, rdy);
        checkOutput("rewalk_busy_cycles", cyc, 16);
        checkOutput("upd_ready_during_rewalk", rdy, 0);

        // Random hit/fill traffic checked against the reference model every cycle
        for (int i = 0; i < 300; i++) begin
            applyStimulus(logic'($urandom_range(0, 1)), SB'($urandom_range(0, NS-1)),
                          2'($urandom_range(0, NW-1)), logic'($urandom_range(0, 3) != 0),
                          SB'($urandom_range(0, NS-1)), 8'h00, 1);
        end
        applyStimulus(0, 4'd0, 2'd0, 0, 4'd0, 8'h00, 0);
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
